// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_pkg;

   typedef enum logic {FETCH, WAIT} fetch_state_t;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch unit with stall, redirect and squash
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   input  logic        MemAck,
   input  logic [31:0] MemInstr,
   output logic [31:0] MemAddress,
   output logic        MemReadEnable,
   output logic        InstrValid,
   output logic [31:0] InstrOut,
   output logic [31:0] PCOut,
   output logic [31:0] PCPlus4
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  pc;
   logic         squash;
   logic [31:0]  target;

   assign target     = RedirectPC & ~32'(INSTR_BYTES - 1);
   assign MemAddress = pc;
   assign PCPlus4    = PCOut + 32'(INSTR_BYTES);

   // A new request goes out only when the output slot is free or being drained this edge.
   always_comb begin
      MemReadEnable = 1'b0;
      state_next    = state;
      if (!RST && state == FETCH && (!InstrValid || !Stall) && !Redirect) begin
         MemReadEnable = 1'b1;
      end
      case (state)
         FETCH: if (MemReadEnable) state_next = WAIT;
         WAIT:  if (MemAck)        state_next = FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         squash     <= 1'b0;
         InstrValid <= 1'b0;
         InstrOut   <= NOP_INSTR;
         PCOut      <= 32'h0000_0000;
      end else begin
         state <= state_next;
         if (Redirect) begin
            pc         <= target;
            InstrValid <= 1'b0;
            // An in-flight response that has not yet returned must be thrown away.
            if (state == WAIT) squash <= !MemAck;
         end else if (state == WAIT && MemAck) begin
            if (squash) begin
               squash <= 1'b0;
            end else begin
               InstrOut   <= MemInstr;
               PCOut      <= pc;
               InstrValid <= 1'b1;
               pc         <= pc + 32'(INSTR_BYTES);
            end
         end else if (InstrValid && !Stall) begin
            InstrValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        Stall = 1'b0;
   logic        Redirect = 1'b0;
   logic [31:0] RedirectPC = 32'h0;
   logic        MemAck;
   logic [31:0] MemInstr;
   logic [31:0] MemAddress;
   logic        MemReadEnable;
   logic        InstrValid;
   logic [31:0] InstrOut;
   logic [31:0] PCOut;
   logic [31:0] PCPlus4;

   logic        MemAck2;
   logic [31:0] MemInstr2;
   logic [31:0] MemAddress2;
   logic        MemReadEnable2;
   logic        InstrValid2;
   logic [31:0] InstrOut2;
   logic [31:0] PCOut2;
   logic [31:0] PCPlus42;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .CLK(CLK), .RST(RST), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
      .MemAck(MemAck), .MemInstr(MemInstr), .MemAddress(MemAddress),
      .MemReadEnable(MemReadEnable), .InstrValid(InstrValid), .InstrOut(InstrOut),
      .PCOut(PCOut), .PCPlus4(PCPlus4));

   instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .CLK(CLK), .RST(RST), .Stall(1'b0), .Redirect(1'b0), .RedirectPC(32'h0),
      .MemAck(MemAck2), .MemInstr(MemInstr2), .MemAddress(MemAddress2),
      .MemReadEnable(MemReadEnable2), .InstrValid(InstrValid2), .InstrOut(InstrOut2),
      .PCOut(PCOut2), .PCPlus4(PCPlus42));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Memory models: response arrives lat cycles after the sampled request.
   int          lat = 1;
   int          cnt = 0;
   int          cnt2 = 0;
   logic [31:0] maddr = 32'h0;
   logic [31:0] maddr2 = 32'h0;
   int          cyc = 0;
   logic [31:0] req_addr[$];
   int          req_cyc[$];
   logic [31:0] req2_addr[$];

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (RST) cnt <= 0;
      else if (MemReadEnable) begin
         cnt   <= lat;
         maddr <= MemAddress;
         req_addr.push_back(MemAddress);
         req_cyc.push_back(cyc);
      end else if (cnt > 0) cnt <= cnt - 1;
      if (RST) cnt2 <= 0;
      else if (MemReadEnable2) begin
         cnt2   <= 1;
         maddr2 <= MemAddress2;
         req2_addr.push_back(MemAddress2);
      end else if (cnt2 > 0) cnt2 <= cnt2 - 1;
   end

   assign MemAck    = (cnt == 1);
   assign MemInstr  = MemAck ? mem_word(maddr) : 32'hDEAD_BEEF;
   assign MemAck2   = (cnt2 == 1);
   assign MemInstr2 = MemAck2 ? mem_word(maddr2) : 32'hDEAD_BEEF;

   // Transaction-level reference: next address to fetch, in-flight request, whether it is doomed.
   logic [31:0] m_next = 32'h0;
   logic        m_out = 1'b0;
   logic        m_stale = 1'b0;
   logic        m_valid = 1'b0;
   logic [31:0] m_instr = NOP_INSTR;
   logic [31:0] m_pc = 32'h0;

   task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
      logic exp_mre;
      Stall = st; Redirect = rd; RedirectPC = rpc;
      #1;
      exp_mre = !RST && !m_out && (!m_valid || !st) && !rd;
      checks++; if (MemReadEnable !== exp_mre) begin errors++;
         $display("FAIL read_enable t=%0t got %b want %b", $time, MemReadEnable, exp_mre); end
      checks++; if (MemAddress !== m_next) begin errors++;
         $display("FAIL mem_address t=%0t got %h want %h", $time, MemAddress, m_next); end
      checks++; if (InstrValid !== m_valid) begin errors++;
         $display("FAIL instr_valid t=%0t got %b want %b", $time, InstrValid, m_valid); end
      checks++; if (InstrOut !== m_instr) begin errors++;
         $display("FAIL instr_out t=%0t got %h want %h", $time, InstrOut, m_instr); end
      checks++; if (PCOut !== m_pc) begin errors++;
         $display("FAIL pc_out t=%0t got %h want %h", $time, PCOut, m_pc); end
      checks++; if (PCPlus4 !== m_pc + 32'd4) begin errors++;
         $display("FAIL pc_plus4 t=%0t got %h want %h", $time, PCPlus4, m_pc + 32'd4); end
      checks++; if (MemReadEnable && MemAck) begin errors++;
         $display("FAIL strobe_collision t=%0t read_enable %b ack %b want no overlap", $time, MemReadEnable, MemAck); end
      if (RST) begin
         m_next = 32'h0; m_out = 0; m_stale = 0; m_valid = 0; m_instr = NOP_INSTR; m_pc = 32'h0;
      end else if (rd) begin
         m_next  = rpc & ~32'd3;
         m_valid = 0;
         if (m_out) begin
            if (MemAck) begin m_out = 0; m_stale = 0; end
            else m_stale = 1;
         end
      end else if (m_out && MemAck) begin
         m_out = 0;
         if (m_stale) m_stale = 0;
         else begin
            m_valid = 1; m_instr = mem_word(m_next); m_pc = m_next; m_next = m_next + 32'd4;
         end
      end else begin
         if (m_valid && !st) m_valid = 0;
         if (exp_mre) m_out = 1;
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset(input int l);
      lat = l;
      RST = 1;
      cycle(0, 0, 32'h0);
      RST = 0;
      req_addr.delete(); req_cyc.delete(); req2_addr.delete();
   endtask

   task automatic test_reset;
      RST = 1; Stall = 0; Redirect = 0;
      @(posedge CLK); @(negedge CLK);
      cycle(0, 0, 32'h0);
      checks++; if (MemAddress !== 32'h0) begin errors++;
         $display("FAIL reset_pc got %h want %h", MemAddress, 32'h0); end
      checks++; if (MemAddress2 !== 32'hFFFF_FFFC) begin errors++;
         $display("FAIL reset_pc_wrap got %h want %h", MemAddress2, 32'hFFFF_FFFC); end
      RST = 0;
   endtask

   task automatic test_free_run;
      do_reset(1);
      repeat (7) cycle(0, 0, 32'h0);
      checks++; if (req_addr.size() < 3) begin errors++;
         $display("FAIL free_run_count got %0d want >=3", req_addr.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (req_addr[i] !== 32'(4 * i)) begin errors++;
               $display("FAIL free_run_addr%0d got %h want %h", i, req_addr[i], 32'(4 * i)); end
         end
         checks++; if (req_cyc[1] - req_cyc[0] != 2 || req_cyc[2] - req_cyc[1] != 2) begin errors++;
            $display("FAIL free_run_spacing got %0d,%0d want 2,2", req_cyc[1] - req_cyc[0], req_cyc[2] - req_cyc[1]); end
      end
   endtask

   task automatic test_stall;
      logic        found;
      logic [31:0] snap;
      do_reset(1);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (InstrValid && PCOut == 32'h4) begin found = 1; break; end
         cycle(0, 0, 32'h0);
      end
      checks++; if (!found) begin errors++;
         $display("FAIL stall_reach got valid %b pc %h want valid at 00000004", InstrValid, PCOut); end
      snap = InstrOut;
      req_addr.delete();
      repeat (5) begin
         cycle(1, 0, 32'h0);
         checks++; if (InstrOut !== snap || PCOut !== 32'h4 || InstrValid !== 1'b1) begin errors++;
            $display("FAIL stall_hold got %h/%h/%b want %h/00000004/1", InstrOut, PCOut, InstrValid, snap); end
      end
      checks++; if (req_addr.size() != 0) begin errors++;
         $display("FAIL stall_no_read got %0d reads want 0", req_addr.size()); end
      repeat (3) cycle(0, 0, 32'h0);
      checks++; if (req_addr.size() == 0 || req_addr[0] !== 32'h8) begin errors++;
         $display("FAIL stall_next_read got %h want 00000008", req_addr.size() ? req_addr[0] : 32'hX); end
   endtask

   task automatic test_redirect_wait;
      do_reset(2);
      cycle(0, 0, 32'h0);
      req_addr.delete();
      cycle(0, 1, 32'h40);
      cycle(0, 0, 32'h0);
      checks++; if (InstrValid !== 1'b0) begin errors++;
         $display("FAIL redirect_wait_valid got %b want 0", InstrValid); end
      repeat (4) cycle(0, 0, 32'h0);
      checks++; if (req_addr.size() == 0 || req_addr[0] !== 32'h40) begin errors++;
         $display("FAIL redirect_wait_next got %h want 00000040", req_addr.size() ? req_addr[0] : 32'hX); end
   endtask

   task automatic test_redirect_ack;
      do_reset(1);
      cycle(0, 0, 32'h0);
      req_addr.delete();
      cycle(0, 1, 32'h103);
      checks++; if (InstrValid !== 1'b0) begin errors++;
         $display("FAIL redirect_ack_valid got %b want 0", InstrValid); end
      repeat (3) cycle(0, 0, 32'h0);
      checks++; if (req_addr.size() == 0 || req_addr[0] !== 32'h100) begin errors++;
         $display("FAIL redirect_ack_next got %h want 00000100", req_addr.size() ? req_addr[0] : 32'hX); end
   endtask

   task automatic test_reset_in_wait;
      do_reset(3);
      repeat (3) cycle(0, 0, 32'h0);
      cycle(0, 0, 32'h0);
      RST = 1;
      cycle(0, 0, 32'h0);
      RST = 0;
      req_addr.delete();
      checks++; if (InstrValid !== 1'b0) begin errors++;
         $display("FAIL reset_wait_valid got %b want 0", InstrValid); end
      repeat (6) cycle(0, 0, 32'h0);
      checks++; if (req_addr.size() == 0 || req_addr[0] !== 32'h0) begin errors++;
         $display("FAIL reset_wait_next got %h want 00000000", req_addr.size() ? req_addr[0] : 32'hX); end
   endtask

   task automatic test_wrap;
      logic seen;
      do_reset(1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (InstrValid2 && PCOut2 == 32'hFFFF_FFFC) begin
            seen = 1;
            checks++; if (PCPlus42 !== 32'h0 || InstrOut2 !== mem_word(32'hFFFF_FFFC)) begin errors++;
               $display("FAIL wrap_output got %h/%h want 00000000/%h", PCPlus42, InstrOut2, mem_word(32'hFFFF_FFFC)); end
         end
         cycle(0, 0, 32'h0);
      end
      checks++; if (!seen) begin errors++;
         $display("FAIL wrap_seen got 0 want 1"); end
      checks++; if (req2_addr.size() < 2 || req2_addr[0] !== 32'hFFFF_FFFC || req2_addr[1] !== 32'h0) begin errors++;
         $display("FAIL wrap_reads got %0d reads, second %h want FFFFFFFC then 00000000",
                  req2_addr.size(), req2_addr.size() > 1 ? req2_addr[1] : 32'hX); end
   endtask

   task automatic test_random;
      for (int seg = 0; seg < 3; seg++) begin
         do_reset(1 + seg);
         for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            r = $urandom;
            RST = ($urandom_range(0, 99) == 0);
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (r & 32'hF)) : r);
         end
         RST = 0;
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_redirect_wait();
      test_redirect_ack();
      test_reset_in_wait();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 Stall  input  1  decode cannot accept the presented instruction this cycle.
REQ-005 Redirect  input  1  branch/jump taken; restart fetch at RedirectPC.
REQ-006 RedirectPC  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-007 MemAck  input  1  instruction memory response strobe, one cycle wide.
REQ-008 MemInstr  input  32  instruction word; valid only while MemAck=1.
REQ-009 MemAddress  output  32  byte address to instruction memory; equals PC.
REQ-010 MemReadEnable  output  1  single-cycle read request strobe.
REQ-011 InstrValid  output  1  InstrOut/PCOut hold a valid instruction for decode.
REQ-012 InstrOut  output  32  fetched instruction, registered.
REQ-013 PCOut  output  32  byte address of InstrOut, registered.
REQ-014 PCPlus4  output  32  PCOut+4, combinational from PCOut.

Function
REQ-015 Memory contract: the read is sampled on the rising edge where MemReadEnable=1; MemAck=1 and MemInstr valid in the following cycle.
REQ-016 FSM states are FETCH and WAIT; there is one outstanding request at most.
REQ-017 MemReadEnable = (state==FETCH) && (!InstrValid || !Stall) && !Redirect; it is never high in WAIT.
REQ-018 FETCH -> WAIT when MemReadEnable=1; otherwise the FSM stays in FETCH.
REQ-019 WAIT -> FETCH on MemAck=1; otherwise the FSM stays in WAIT with no timeout.
REQ-020 On MemAck in WAIT with Squash=0 and Redirect=0:
  - InstrOut<=MemInstr, PCOut<=PC, InstrValid<=1.
  - PC<=PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 Consume: InstrValid=1 and Stall=0 at an edge without a load clears InstrValid.
REQ-022 Stall=1 holds InstrValid, InstrOut and PCOut unchanged.
REQ-023 Throughput is at most one instruction per two cycles; back-to-back strobes are forbidden because memory drops an Ack when ReadEnable and Ack coincide.
REQ-024 Redirect in FETCH: PC<=RedirectPC&~3, InstrValid<=0, no request issued that cycle.
REQ-025 Redirect in WAIT without MemAck: PC<=RedirectPC&~3, InstrValid<=0, Squash<=1.
REQ-026 Redirect in WAIT with MemAck: discard MemInstr, PC<=RedirectPC&~3, InstrValid<=0, go to FETCH.
REQ-027 MemAck with Squash=1: discard data, Squash<=0, PC unchanged, go to FETCH.
REQ-028 A later Redirect overrides an earlier one; the last target wins.
REQ-029 Redirect has priority over Stall and over MemAck.
REQ-030 MemAck received in FETCH is ignored.

Reset
REQ-031 On RST:
  - state<=FETCH, PC<=RESET_PC, Squash<=0.
  - InstrValid<=0, InstrOut<=0, PCOut<=0.
REQ-032 MemReadEnable=0 whenever RST=1.
REQ-033 RST mid-WAIT abandons the request; the first request after reset is to RESET_PC.

Structure
REQ-034 The shared package holds:
  - enum fetch_state_t {FETCH, WAIT}.
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h0000_0000.
REQ-035 The block is a single module with no sub-module; PC, Squash and the output register are local.

Verification
REQ-036 Bench memory model: 1-cycle Ack; it flags an error if MemReadEnable is high in the same cycle as Ack.
REQ-037 Scenario, free run: release RST, Stall=0 -> reads at 0x0,0x4,0x8 on cycles 1,3,5; each PCOut matches its InstrOut; PCPlus4 = PCOut+4.
REQ-038 Scenario, stall: Stall=1 for 5 cycles while InstrValid=1 at PC 0x4 -> outputs frozen, no MemReadEnable; on release, the next read is 0x8.
REQ-039 Scenario, redirect in WAIT: Redirect with RedirectPC=0x40 -> late Ack dropped, InstrValid stays 0, next read 0x40.
REQ-040 Scenario, Redirect coincident with MemAck: RedirectPC=0x103 -> data discarded, next read 0x100.
REQ-041 Scenario, wrap: RESET_PC=32'hFFFF_FFFC -> second read at 0x0.
REQ-042 Scenario, reset in WAIT: RST pulsed in WAIT -> InstrValid=0, next read RESET_PC, no stray valid.
